// File: rtl/shift_register_74299_if.sv
// Control and serial-link signals of one SN74LS299-style shift/storage register.
// The device takes the slave side; whatever steers the register takes the master side.
interface shift_register_74299_if;
  logic [1:0] s;
  logic       g1_n;
  logic       g2_n;
  logic       sr;
  logic       sl;
  logic       qa_s;
  logic       qh_s;

  modport master (
    output s, g1_n, g2_n, sr, sl,
    input  qa_s, qh_s
  );

  modport slave (
    input  s, g1_n, g2_n, sr, sl,
    output qa_s, qh_s
  );
endinterface

// File: rtl/shift_register_74299.sv
// 8-bit universal shift/storage register (SN74LS299 / K555IR24) with a
// 3-state bidirectional byte port, asynchronous active-low clear.
module shift_register_74299 #(
  parameter int DELAY = 20
) (
  input  logic                         clk,
  input  logic                         clr_n,
  inout  wire  [7:0]                   io,
  shift_register_74299_if.slave        bus
);

  logic [7:0] q;
  logic [7:0] q_next;
  logic       io_drive;

  // DELAY only describes the part's pin timing; the logic itself is zero-delay.
  wire unused_delay;
  assign unused_delay = (DELAY != 0);

  always_comb begin
    q_next = q;
    case (bus.s)
      2'b01:   q_next = {q[6:0], bus.sr};
      2'b10:   q_next = {bus.sl, q[7:1]};
      2'b11:   q_next = io;
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= 8'h00;
    end else begin
      q <= q_next;
    end
  end

  // Load mode always releases the pins so they can act as inputs.
  assign io_drive = !bus.g1_n && !bus.g2_n && (bus.s != 2'b11);
  assign io       = io_drive ? q : 8'bz;

  assign bus.qa_s = q[0];
  assign bus.qh_s = q[7];

endmodule

// File: tb/tb_shift_register_74299.sv
// Directed bench for shift_register_74299: a vector table of single-cycle
// operations plus hand-written sequences for clear, bus release and cascading.
module tb_shift_register_74299;

  logic clk;
  logic clr_n;

  wire  [7:0] io0;
  logic [7:0] drv0;
  logic       oe0;
  wire  [7:0] io1;
  logic [7:0] drv1;
  logic       oe1;
  wire  [7:0] io2;
  logic [7:0] drv2;
  logic       oe2;

  assign io0 = oe0 ? drv0 : 8'bz;
  assign io1 = oe1 ? drv1 : 8'bz;
  assign io2 = oe2 ? drv2 : 8'bz;

  shift_register_74299_if bus0 ();
  shift_register_74299_if bus1 ();
  shift_register_74299_if bus2 ();

  // Cascade wiring: U1 feeds U2 on right shifts, U2 feeds U1 on left shifts.
  assign bus2.sr = bus1.qh_s;
  assign bus1.sl = bus2.qa_s;

  shift_register_74299 #(.DELAY(20)) u_dut (.clk(clk), .clr_n(clr_n), .io(io0), .bus(bus0));
  shift_register_74299 #(.DELAY(20)) u1    (.clk(clk), .clr_n(clr_n), .io(io1), .bus(bus1));
  shift_register_74299 #(.DELAY(20)) u2    (.clk(clk), .clr_n(clr_n), .io(io2), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef struct {
    logic [1:0] s;
    logic       sr;
    logic       sl;
    logic       g1_n;
    logic       g2_n;
    logic [7:0] din;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic load0(input logic [7:0] d);
    drv0 = d;
    oe0 = 1'b1;
    bus0.s = 2'b11;
    tick();
    oe0 = 1'b0;
    bus0.s = 2'b00;
  endtask

  // Put U0 into hold with both enables on so io shows q.
  task automatic observe0();
    oe0 = 1'b0;
    bus0.s = 2'b00;
    bus0.g1_n = 1'b0;
    bus0.g2_n = 1'b0;
    #1;
  endtask

  task automatic check_q0(input string name, input logic [7:0] exp);
    observe0();
    check8({name, " io"}, io0, exp);
    check1({name, " qa_s"}, bus0.qa_s, exp[0]);
    check1({name, " qh_s"}, bus0.qh_s, exp[7]);
  endtask

  initial begin
    logic [7:0] qh_pat;
    total = 0;
    bad = 0;
    clr_n = 1'b1;
    oe0 = 1'b0; oe1 = 1'b0; oe2 = 1'b0;
    drv0 = 8'h00; drv1 = 8'h00; drv2 = 8'h00;
    bus0.s = 2'b00; bus0.g1_n = 1'b0; bus0.g2_n = 1'b0; bus0.sr = 1'b0; bus0.sl = 1'b0;
    bus1.s = 2'b00; bus1.g1_n = 1'b0; bus1.g2_n = 1'b0; bus1.sr = 1'b0;
    bus2.s = 2'b00; bus2.g1_n = 1'b0; bus2.g2_n = 1'b0; bus2.sl = 1'b0;

    //          s      sr    sl    g1    g2    din    exp_q
    vecs[0]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5};
    vecs[1]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h4B};
    vecs[2]  = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h25};
    vecs[3]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h25};
    vecs[4]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h92};
    vecs[5]  = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h24};
    vecs[6]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[7]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFE};
    vecs[8]  = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h7F};
    vecs[9]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80};
    vecs[11] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h80};

    // Clear with a known non-zero prior value, no clock involved.
    tick();
    load0(8'h5A);
    observe0();
    check8("preload io", io0, 8'h5A);
    #1 clr_n = 1'b0;
    #1;
    check8("clear io", io0, 8'h00);
    check1("clear qa_s", bus0.qa_s, 1'b0);
    check1("clear qh_s", bus0.qh_s, 1'b0);
    bus0.s = 2'b01;
    bus0.sr = 1'b1;
    tick();
    tick();
    check8("clock during clear io", io0, 8'h00);
    clr_n = 1'b1;
    bus0.s = 2'b00;
    bus0.sr = 1'b0;

    // Table of single-cycle operations; enables toggled during some of them.
    for (int i = 0; i < 12; i++) begin
      bus0.s = vecs[i].s;
      bus0.sr = vecs[i].sr;
      bus0.sl = vecs[i].sl;
      bus0.g1_n = vecs[i].g1_n;
      bus0.g2_n = vecs[i].g2_n;
      drv0 = vecs[i].din;
      oe0 = (vecs[i].s == 2'b11);
      tick();
      check_q0($sformatf("vec%0d", i), vecs[i].exp_q);
    end

    // Load then drive; a disabled port must let the bench own the pins.
    load0(8'hA5);
    check_q0("drive A5", 8'hA5);
    bus0.g2_n = 1'b1;
    drv0 = 8'h5A;
    oe0 = 1'b1;
    #1;
    check8("released io", io0, 8'h5A);
    check1("released qa_s", bus0.qa_s, 1'b1);
    check1("released qh_s", bus0.qh_s, 1'b1);
    oe0 = 1'b0;
    bus0.g2_n = 1'b0;

    // Mode changes between edges must not touch q.
    bus0.s = 2'b01;
    #1 bus0.s = 2'b10;
    #1 bus0.s = 2'b11;
    #1;
    check_q0("mode wiggle", 8'hA5);

    // Shift right 8'h81 out through QH'.
    load0(8'h81);
    qh_pat = 8'b1000_0001;
    bus0.s = 2'b01;
    bus0.sr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check1($sformatf("shr qh_s[%0d]", i), bus0.qh_s, qh_pat[i]);
      tick();
    end
    check_q0("shr final", 8'h00);

    // Shift left with ones entering at QH.
    load0(8'h01);
    bus0.s = 2'b10;
    bus0.sl = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_q0("shl fill", 8'hE0);

    // Hold, then clear in the middle of right shifting.
    load0(8'h3C);
    for (int i = 0; i < 5; i++) tick();
    check_q0("hold 3C", 8'h3C);
    bus0.s = 2'b01;
    bus0.sr = 1'b0;
    tick();
    check8("shift before clear", io0, 8'h78);
    #2 clr_n = 1'b0;
    #1;
    check8("mid-shift clear io", io0, 8'h00);
    clr_n = 1'b1;
    bus0.sr = 1'b1;
    tick();
    check_q0("first edge after clear", 8'h01);

    // Two devices cascaded into a 16-bit shifter.
    drv1 = 8'hF0; drv2 = 8'h0F;
    oe1 = 1'b1; oe2 = 1'b1;
    bus1.s = 2'b11; bus2.s = 2'b11;
    tick();
    oe1 = 1'b0; oe2 = 1'b0;
    bus1.s = 2'b01; bus2.s = 2'b01;
    bus1.sr = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    bus1.s = 2'b00; bus2.s = 2'b00;
    #1;
    check8("cascade shr U1", io1, 8'h00);
    check8("cascade shr U2", io2, 8'hF0);
    bus1.s = 2'b10; bus2.s = 2'b10;
    bus2.sl = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    bus1.s = 2'b00; bus2.s = 2'b00;
    #1;
    check8("cascade shl U1", io1, 8'hF0);
    check8("cascade shl U2", io2, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
